// File: rtl/dot4x_clockgen_supervisor.sv
// ---------------------------------------------------------------------------
// dot4x_clockgen_supervisor
//
// Free-running supervisor for the dot4x clock generator, clocked by the
// 12 MHz board clock. It pulses the MMCM reset and waits for LOCKED, with a
// timeout and a bounded number of retries. Lock must then stay stable for a
// qualification window before the dot4x system reset request is released.
// Any loss of lock after release re-sequences the MMCM from the reset pulse.
//
// Ports:
//   clk_in12mhz     in   free-running 12 MHz clock, sole clock of this block
//   reset           in   asynchronous, active-high reset
//   locked          in   MMCM LOCKED, asynchronous to clk_in12mhz
//   clk_reset       out  MMCM RST request, active high (registered)
//   sys_reset       out  dot4x domain reset request, active high (registered)
//   fail            out  lock never achieved within MAX_RETRIES attempts
//   retry_count     out  lock timeouts since reset, saturating at 255
//   lock_loss_count out  lock drops seen while running, saturating
//
// Optional feature macro: LOCK_LOSS_COUNT_EN
//   defined   -> lock_loss_count is a live saturating counter
//   undefined -> no counter register; lock_loss_count is tied to zero
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module dot4x_clockgen_supervisor #(
  parameter int unsigned RST_CYCLES    = 8,
  parameter int unsigned LOCK_TIMEOUT  = 12000,
  parameter int unsigned STABLE_CYCLES = 1200,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk_in12mhz,
  input  logic             reset,
  input  logic             locked,
  output logic             clk_reset,
  output logic             sys_reset,
  output logic             fail,
  output logic [7:0]       retry_count,
  output logic [CNT_W-1:0] lock_loss_count
);

  typedef enum logic [2:0] {
    ST_RST_PULSE = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRIES);

  state_t      state;
  state_t      state_next;
  logic [15:0] timer;
  logic        lk_meta;
  logic        lk_s;
  logic        retry_inc;
  logic [7:0]  retry_sat;
  logic        timed_state;

  // Two-flop synchronizer for the asynchronous LOCKED input. Every decision
  // below uses lk_s only, so locked reaches the FSM two edges late.
  always_ff @(posedge clk_in12mhz or posedge reset) begin
    if (reset) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= locked;
      lk_s    <= lk_meta;
    end
  end

  // Retry count as it would be after one more timeout, saturating at 255.
  // The fail decision looks at this post-increment value.
  assign retry_sat   = (retry_count == 8'hFF) ? 8'hFF : retry_count + 8'd1;
  assign timed_state = (state == ST_RST_PULSE) || (state == ST_WAIT_LOCK) ||
                       (state == ST_STABLE);

  // Next-state decode. In WAIT_LOCK a synchronized lock beats a timeout
  // landing on the same cycle. FAIL is terminal until reset.
  always_comb begin
    state_next = state;
    retry_inc  = 1'b0;
    case (state)
      ST_RST_PULSE: begin
        if (timer == RST_LAST) state_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lk_s) begin
          state_next = ST_STABLE;
        end else if (timer == LOCK_LAST) begin
          retry_inc  = 1'b1;
          state_next = (retry_sat >= RETRY_LIMIT) ? ST_FAIL : ST_RST_PULSE;
        end
      end
      ST_STABLE: begin
        if (!lk_s)                     state_next = ST_RST_PULSE;
        else if (timer == STABLE_LAST) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!lk_s) state_next = ST_RST_PULSE;
      end
      ST_FAIL: begin
        state_next = ST_FAIL;
      end
      default: begin
        state_next = ST_RST_PULSE;
      end
    endcase
  end

  // State register and the shared timer. The timer restarts from zero on
  // every state change and only advances in the timed states, so each
  // timed state sees 0..N-1 before its exit condition fires.
  always_ff @(posedge clk_in12mhz or posedge reset) begin
    if (reset) begin
      state <= ST_RST_PULSE;
      timer <= 16'd0;
    end else begin
      state <= state_next;
      if (state_next != state) timer <= 16'd0;
      else if (timed_state)    timer <= timer + 16'd1;
    end
  end

  // Outputs are registered from the next state, so they change on the same
  // edge as the state itself and never see locked combinationally. This is
  // what makes sys_reset and clk_reset reassert together on a lock drop.
  always_ff @(posedge clk_in12mhz or posedge reset) begin
    if (reset) begin
      clk_reset   <= 1'b1;
      sys_reset   <= 1'b1;
      fail        <= 1'b0;
      retry_count <= 8'd0;
    end else begin
      clk_reset <= (state_next == ST_RST_PULSE);
      sys_reset <= (state_next != ST_RUN);
      fail      <= (state_next == ST_FAIL);
      if (retry_inc) retry_count <= retry_sat;
    end
  end

`ifdef LOCK_LOSS_COUNT_EN
  logic [CNT_W-1:0] loss_q;

  // Counts drops of synchronized lock while running; sticks at all-ones.
  always_ff @(posedge clk_in12mhz or posedge reset) begin
    if (reset) begin
      loss_q <= '0;
    end else if ((state == ST_RUN) && !lk_s && (loss_q != {CNT_W{1'b1}})) begin
      loss_q <= loss_q + CNT_W'(1);
    end
  end

  assign lock_loss_count = loss_q;
`else
  assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_dot4x_clockgen_supervisor.sv
`timescale 1ns/1ps

module tb_dot4x_clockgen_supervisor;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 10;
  localparam int MAX_RETRIES   = 2;
  localparam int CNT_W         = 8;

`ifdef LOCK_LOSS_COUNT_EN
  localparam bit LLC_EN = 1'b1;
`else
  localparam bit LLC_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             locked = 1'b0;
  logic             clk_reset;
  logic             sys_reset;
  logic             fail;
  logic [7:0]       retry_count;
  logic [CNT_W-1:0] lock_loss_count;

  int checks = 0;
  int errors = 0;

  bit watchSys = 1'b0;
  bit sawRelease = 1'b0;

  dot4x_clockgen_supervisor #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES  (MAX_RETRIES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk_in12mhz    (clk),
    .reset          (reset),
    .locked         (locked),
    .clk_reset      (clk_reset),
    .sys_reset      (sys_reset),
    .fail           (fail),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count)
  );

  // Free-running board clock.
  always #5 clk = ~clk;

  // Flags any sys_reset release while a glitch window is being watched.
  always @(negedge clk) begin
    if (watchSys && (sys_reset === 1'b0)) sawRelease <= 1'b1;
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive locked, then let the given number of cycles pass (negedge to negedge).
  task automatic applyStimulus(input logic lockVal, input int cycles);
    locked = lockVal;
    repeat (cycles) @(negedge clk);
  endtask

  // Hold reset for a few cycles, check reset values, release on a negedge.
  task automatic doReset(input string tag);
    @(negedge clk);
    reset  = 1'b1;
    locked = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput({tag, "_rst_clk_reset"}, 32'(clk_reset), 32'd1);
    checkOutput({tag, "_rst_sys_reset"}, 32'(sys_reset), 32'd1);
    checkOutput({tag, "_rst_fail"}, 32'(fail), 32'd0);
    checkOutput({tag, "_rst_retry"}, 32'(retry_count), 32'd0);
    checkOutput({tag, "_rst_loss"}, 32'(lock_loss_count), 32'd0);
    reset = 1'b0;
  endtask

  // Number of negedge samples clk_reset stays high, waiting (bounded) for it
  // to go high first. Ends on the first sample where it is low again.
  task automatic measurePulse(output int n);
    int guard;
    guard = 0;
    n = 0;
    while ((clk_reset !== 1'b1) && (guard < 200)) begin
      @(negedge clk);
      guard++;
    end
    while ((clk_reset === 1'b1) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic waitClkResetHigh(output int n);
    n = 0;
    while ((clk_reset !== 1'b1) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic waitSysLow(output int n);
    n = 0;
    while ((sys_reset !== 1'b0) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int timeouts;
    bit changed;

    // Normal bring-up. locked goes high 3 cycles into WAIT_LOCK; the first
    // edge sampling it is followed by 2 sync edges plus 10 stable edges.
    doReset("s1");
    measurePulse(n);
    checkOutput("s1_pulse_len", 32'(n), 32'd4);
    applyStimulus(1'b0, 3);
    locked = 1'b1;
    @(negedge clk);
    checkOutput("s1_sys_held", 32'(sys_reset), 32'd1);
    waitSysLow(n);
    checkOutput("s1_release_delay", 32'(n), 32'd12);
    checkOutput("s1_clk_reset", 32'(clk_reset), 32'd0);
    checkOutput("s1_retry", 32'(retry_count), 32'd0);
    checkOutput("s1_fail", 32'(fail), 32'd0);

    // Single timeout: 20 WAIT_LOCK cycles, second pulse, then lock.
    doReset("s2");
    measurePulse(n);
    checkOutput("s2_pulse1_len", 32'(n), 32'd4);
    waitClkResetHigh(n);
    checkOutput("s2_wait_len", 32'(n), 32'd20);
    checkOutput("s2_retry_after_timeout", 32'(retry_count), 32'd1);
    checkOutput("s2_sys_held", 32'(sys_reset), 32'd1);
    measurePulse(n);
    checkOutput("s2_pulse2_len", 32'(n), 32'd4);
    locked = 1'b1;
    waitSysLow(n);
    checkOutput("s2_run_delay", 32'(n), 32'd13);
    checkOutput("s2_fail", 32'(fail), 32'd0);
    checkOutput("s2_retry", 32'(retry_count), 32'd1);

    // Fail: 4 + 20 + 4 + 20 cycles from reset release to FAIL.
    doReset("s3");
    n = 0;
    while ((fail !== 1'b1) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("s3_fail_time", 32'(n), 32'd48);
    checkOutput("s3_retry", 32'(retry_count), 32'd2);
    checkOutput("s3_clk_reset", 32'(clk_reset), 32'd0);
    checkOutput("s3_sys_reset", 32'(sys_reset), 32'd1);
    locked  = 1'b1;
    changed = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if ((fail !== 1'b1) || (clk_reset !== 1'b0) || (sys_reset !== 1'b1) ||
          (retry_count !== 8'd2)) changed = 1'b1;
    end
    checkOutput("s3_fail_held", 32'(changed), 32'd0);

    // Glitch on the 5th STABLE cycle (timer 4) sends us back to the pulse.
    doReset("s4");
    measurePulse(n);
    checkOutput("s4_pulse1_len", 32'(n), 32'd4);
    sawRelease = 1'b0;
    watchSys   = 1'b1;
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 1);
    locked = 1'b1;
    waitClkResetHigh(n);
    checkOutput("s4_glitch_to_pulse", 32'(n), 32'd2);
    measurePulse(n);
    checkOutput("s4_pulse2_len", 32'(n), 32'd4);
    watchSys = 1'b0;
    checkOutput("s4_sys_held", 32'(sawRelease), 32'd0);
    checkOutput("s4_retry", 32'(retry_count), 32'd0);
    waitSysLow(n);
    checkOutput("s4_run", 32'(sys_reset), 32'd0);

    // Lock loss in RUN, then 299 more drops to reach saturation.
    checkOutput("s5_loss_init", 32'(lock_loss_count), 32'd0);
    locked = 1'b0;
    @(negedge clk);
    waitClkResetHigh(n);
    checkOutput("s5_drop_to_reset", 32'(n), 32'd2);
    checkOutput("s5_sys_with_clk", 32'(sys_reset), 32'd1);
    checkOutput("s5_loss_1", 32'(lock_loss_count), LLC_EN ? 32'd1 : 32'd0);
    locked = 1'b1;
    waitSysLow(n);
    checkOutput("s5_relock_run", 32'(sys_reset), 32'd0);
    timeouts = 0;
    for (int i = 2; i <= 300; i++) begin
      locked = 1'b0;
      waitClkResetHigh(n);
      if (clk_reset !== 1'b1) timeouts++;
      locked = 1'b1;
      waitSysLow(n);
      if (sys_reset !== 1'b0) timeouts++;
      if (i == 255) checkOutput("s5_loss_255", 32'(lock_loss_count), LLC_EN ? 32'd255 : 32'd0);
    end
    checkOutput("s5_loop_timeouts", 32'(timeouts), 32'd0);
    checkOutput("s5_loss_sat", 32'(lock_loss_count), LLC_EN ? 32'd255 : 32'd0);
    checkOutput("s5_retry", 32'(retry_count), 32'd0);

    // Async reset with WAIT_LOCK timer at 10 and one retry already logged.
    doReset("s6");
    measurePulse(n);
    waitClkResetHigh(n);
    checkOutput("s6_wait_len", 32'(n), 32'd20);
    measurePulse(n);
    applyStimulus(1'b0, 10);
    checkOutput("s6_pre_retry", 32'(retry_count), 32'd1);
    checkOutput("s6_pre_clk_reset", 32'(clk_reset), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("s6_async_clk_reset", 32'(clk_reset), 32'd1);
    checkOutput("s6_async_sys_reset", 32'(sys_reset), 32'd1);
    checkOutput("s6_async_fail", 32'(fail), 32'd0);
    checkOutput("s6_async_retry", 32'(retry_count), 32'd0);
    checkOutput("s6_async_loss", 32'(lock_loss_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    measurePulse(n);
    checkOutput("s6_restart_pulse", 32'(n), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot4x_clockgen_supervisor.md
Name: dot4x_clockgen_supervisor

Overview:
Free-running supervisor on the 12 MHz board clock that sits at the other end of the clockgen's reset/locked pair. It pulses the MMCM reset, waits for LOCKED with a timeout and bounded retries, and qualifies lock stability. It then releases a system reset request for the dot4x domain and re-sequences the MMCM on any lock loss. Downstream dot4x logic synchronizes sys_reset locally.

Parameters:
RST_CYCLES, 8, MMCM reset pulse length in clk_in12mhz cycles (1..65535)
LOCK_TIMEOUT, 12000, max cycles in WAIT_LOCK before retry (1 ms) (1..65535)
STABLE_CYCLES, 1200, cycles synced lock must stay high before release (100 us) (1..65535)
MAX_RETRIES, 3, lock timeouts tolerated before FAIL (1..255)
CNT_W, 8, width of lock_loss_count

Ports:
clk_in12mhz  in  1  free-running 12 MHz input clock, sole clock
reset  in  1  asynchronous, active-high reset
locked  in  1  MMCM LOCKED, asynchronous to clk_in12mhz
clk_reset  out  1  drives clockgen reset (MMCM RST), active high
sys_reset  out  1  reset request for dot4x domain, active high
fail  out  1  lock never achieved within MAX_RETRIES attempts
retry_count  out  8  lock timeouts since reset, saturating at 255
lock_loss_count  out  CNT_W  lock drops after reaching RUN (see optional feature)

Behaviour:
- Reset async active-high. During and after reset: state=RST_PULSE, timer=0, clk_reset=1, sys_reset=1, fail=0, retry_count=0, lock_loss_count=0, sync flops=0.
- locked passes through a 2-flop synchronizer (lk_s). All decisions use lk_s: 2-cycle latency.
- Single 16-bit timer. Cleared on every state entry. Increments once per cycle while in a timed state.
- RST_PULSE: clk_reset=1, sys_reset=1. Lasts exactly RST_CYCLES cycles (timer 0..RST_CYCLES-1). Then goes to WAIT_LOCK.
- WAIT_LOCK: clk_reset=0, sys_reset=1.
  - lk_s=1 -> STABLE.
  - Otherwise, when timer reaches LOCK_TIMEOUT-1: retry_count increments.
    - If the new retry_count >= MAX_RETRIES -> FAIL.
    - Else -> RST_PULSE.
  - Timeout and lk_s=1 in the same cycle: lock wins (-> STABLE, no increment).
- STABLE: clk_reset=0, sys_reset=1.
  - lk_s=0 at any cycle -> RST_PULSE. No retry increment.
  - lk_s=1 continuously for STABLE_CYCLES cycles -> RUN.
- RUN: clk_reset=0. sys_reset=0 starting the first cycle in RUN.
  - lk_s=0 -> RST_PULSE, and lock_loss_count increments, saturating at all-ones.
  - sys_reset reasserts in the same cycle clk_reset reasserts, i.e. registered on the transition.
- FAIL: clk_reset=0, sys_reset=1, fail=1. Terminal; only reset exits. The locked input is ignored.
- All outputs are registered; no combinational path from locked to any output.
- retry_count is not cleared on reaching RUN. It is a diagnostic history since reset.
- Reset mid-sequence: returns immediately to reset values regardless of state or timer.
- Illegal state encoding -> RST_PULSE.

Optional Feature:
Macro LOCK_LOSS_COUNT_EN.
- Defined: lock_loss_count behaves as above.
- Undefined: the counter register is not built, and lock_loss_count is tied to 0. All other behaviour and the port list are unchanged.

Test Plan:
All scenarios use overrides RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=10, MAX_RETRIES=2, with LOCK_LOSS_COUNT_EN defined.
- Normal bring-up: release reset, assert locked 3 cycles after clk_reset falls and hold it.
  -> clk_reset high exactly 4 cycles. sys_reset falls exactly 2+10 cycles after locked rises. retry_count=0, fail=0.
- Single timeout: hold locked=0 through the first WAIT_LOCK, then assert it during the second.
  -> retry_count=1 after 20 WAIT_LOCK cycles, a second 4-cycle clk_reset pulse, then RUN with fail=0.
- Fail: locked held 0 throughout.
  -> two timeouts, retry_count=2, fail=1, clk_reset=0, sys_reset=1. The state persists for 1000 cycles even if locked rises.
- Glitch in STABLE: locked drops for 1 cycle on the 5th STABLE cycle.
  -> return to RST_PULSE (4-cycle pulse). retry_count unchanged. sys_reset never deasserts during the glitch.
- Lock loss in RUN: drop locked after RUN, then relock.
  -> sys_reset=1 and clk_reset=1 registered 2 cycles after the drop. lock_loss_count=1, returns to RUN. Repeat 300 times with CNT_W=8 -> lock_loss_count saturates at 255.
- Async reset mid-WAIT_LOCK (timer=10, retry_count=1).
  -> all outputs return to reset values without a clock edge. The sequence restarts with a 4-cycle clk_reset pulse.
